// File: rtl/output_switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_switch_pkg
// Description : Shared state encoding and default timing constants for the
//               HDMI output source switchover controller.
// Revision    : 1.0 - initial release
// ============================================================================
package output_switch_pkg;

  // Controller states, 3-bit encoded
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_HOLD   = 3'd2;
  localparam logic [2:0] ST_SWITCH = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  // Default timing: 2 muted old-source frames, 3 qualifying new-source
  // frames, 50 ms of silence at 27 MHz counts as a dead source.
  localparam int DEF_MUTE_FRAMES   = 2;
  localparam int DEF_STABLE_FRAMES = 3;
  localparam int DEF_VS_TIMEOUT    = 1350000;
  localparam int DEF_TO_W          = 21;

endpackage
`default_nettype wire

// File: rtl/output_switch_ctrl_vs_sync.sv
`default_nettype none
// ============================================================================
// Module      : vs_sync_edge
// Description : Brings an asynchronous VSYNC into clk27 with a 2-flop
//               synchronizer and emits a registered one-cycle pulse on each
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vs_sync_edge
  import output_switch_pkg::*;
(
  input  logic clk27,
  input  logic reset,
  input  logic i_vs_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;

  // Synchronize, keep the previous synchronized level, register the edge
  always_ff @(posedge clk27) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_vs_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/output_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : output_switch_ctrl
// Description : Frame-aligned, muted switchover of the HDMI output source
//               between scanconverter (0) and videogen (1). Drains the
//               current frame, mutes for MUTE_FRAMES old-source frames, flips
//               the select, then stays muted until STABLE_FRAMES new-source
//               VSYNCs have been seen.
// Revision    : 1.0 - initial release
// ============================================================================
module output_switch_ctrl
  import output_switch_pkg::*;
#(
  parameter int MUTE_FRAMES   = DEF_MUTE_FRAMES,
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES,
  parameter int VS_TIMEOUT    = DEF_VS_TIMEOUT,
  parameter int TO_W          = DEF_TO_W
) (
  input  logic       clk27,
  input  logic       reset,
  input  logic       sel_req,
  input  logic       vs_sc_async,
  input  logic       vs_vg_async,
  output logic       src_sel,
  output logic       mute,
  output logic       vg_run,
  output logic       busy,
  output logic       stable_err,
  output logic [7:0] switch_cnt
);

  localparam logic [3:0]      c_MUTE_N   = MUTE_FRAMES[3:0];
  localparam logic [3:0]      c_STABLE_N = STABLE_FRAMES[3:0];
  localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(VS_TIMEOUT - 1);

  logic            w_sc_rise;
  logic            w_vg_rise;
  logic            w_cur_rise;
  logic            w_to;
  logic            w_tick;
  logic            w_state_chg;
  logic            w_to_clr;
  logic [3:0]      w_frm_inc;
  logic [2:0]      w_next;
  logic [3:0]      w_frm_next;
  logic            w_set_err;

  logic [2:0]      r_state;
  logic [3:0]      r_frm_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_src_sel;
  logic            r_vg_run;
  logic            r_mute;
  logic            r_busy;
  logic            r_stable_err;
  logic [7:0]      r_switch_cnt;
  logic            r_switched;

  vs_sync_edge u_sync_sc (
    .clk27      (clk27),
    .reset      (reset),
    .i_vs_async (vs_sc_async),
    .o_rise     (w_sc_rise)
  );

  vs_sync_edge u_sync_vg (
    .clk27      (clk27),
    .reset      (reset),
    .i_vs_async (vs_vg_async),
    .o_rise     (w_vg_rise)
  );

  // Frame events are taken from whichever source currently drives the output;
  // a timeout stands in for a missing VSYNC so a dead source cannot stall us.
  assign w_cur_rise  = r_src_sel ? w_vg_rise : w_sc_rise;
  assign w_to        = (r_to_cnt == c_TO_LAST);
  assign w_tick      = w_cur_rise | w_to;
  assign w_frm_inc   = r_frm_cnt + 4'd1;
  assign w_state_chg = (w_next != r_state);
  assign w_to_clr    = w_cur_rise | w_to | (r_state == ST_SWITCH) | w_state_chg;

  // Next-state, frame-counter and error-set decode
  always_comb begin
    w_next     = r_state;
    w_frm_next = r_frm_cnt;
    w_set_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sel_req != r_src_sel) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (sel_req == r_src_sel) w_next = ST_IDLE;
        else if (w_tick)          w_next = ST_HOLD;
      end
      ST_HOLD: begin
        // Request withdrawn while muted: same source, just re-qualify it
        if (sel_req == r_src_sel) begin
          w_next = ST_SETTLE;
        end else if (w_tick) begin
          w_frm_next = w_frm_inc;
          if (w_frm_inc == c_MUTE_N) w_next = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        // A real rise takes priority over a coincident timeout
        if (sel_req != r_src_sel) begin
          w_next = ST_SWITCH;
        end else if (w_cur_rise) begin
          w_frm_next = w_frm_inc;
          if (w_frm_inc == c_STABLE_N) w_next = ST_IDLE;
        end else if (w_to) begin
          w_frm_next = 4'd0;
          w_set_err  = 1'b1;
        end
      end
      default: begin
        w_next = ST_SETTLE;
      end
    endcase
    if (w_next != r_state) w_frm_next = 4'd0;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk27) begin
    if (reset) begin
      r_state      <= ST_SETTLE;
      r_frm_cnt    <= 4'd0;
      r_to_cnt     <= '0;
      r_src_sel    <= 1'b1;
      r_vg_run     <= 1'b1;
      r_mute       <= 1'b1;
      r_busy       <= 1'b1;
      r_stable_err <= 1'b0;
      r_switch_cnt <= 8'd0;
      r_switched   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_frm_cnt <= w_frm_next;
      r_to_cnt  <= w_to_clr ? '0 : r_to_cnt + TO_W'(1);
      r_mute    <= (w_next == ST_HOLD) || (w_next == ST_SWITCH) ||
                   (w_next == ST_SETTLE);
      r_busy    <= (w_next != ST_IDLE);
      if (r_state == ST_SWITCH) begin
        r_src_sel  <= sel_req;
        r_vg_run   <= sel_req;
        r_switched <= 1'b1;
      end
      if (w_set_err) r_stable_err <= 1'b1;
      if ((w_next == ST_IDLE) && (r_state != ST_IDLE)) begin
        r_switched <= 1'b0;
        if (r_state == ST_SETTLE) begin
          r_stable_err <= 1'b0;
          if (r_switched) r_switch_cnt <= r_switch_cnt + 8'd1;
        end
      end
    end
  end

  assign src_sel    = r_src_sel;
  assign mute       = r_mute;
  assign vg_run     = r_vg_run;
  assign busy       = r_busy;
  assign stable_err = r_stable_err;
  assign switch_cnt = r_switch_cnt;

endmodule
`default_nettype wire
